// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the wide ALU sequencer.
// Op codes, ALU FunSel codes, flag indices, FSM states, step table.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD32 = 2'b00,
        OP_ADC32 = 2'b01,
        OP_LSL32 = 2'b10,
        OP_LSR32 = 2'b11
    } op_t;

    // bit4 selects 16-bit ALU mode
    localparam logic [4:0] FS_PASSA16 = 5'b10000;
    localparam logic [4:0] FS_ADD16   = 5'b10100;
    localparam logic [4:0] FS_ADC16   = 5'b10101;
    localparam logic [4:0] FS_LSL16   = 5'b11011;
    localparam logic [4:0] FS_LSR16   = 5'b11100;
    localparam logic [4:0] FS_CSL16   = 5'b11110;
    localparam logic [4:0] FS_CSR16   = 5'b11111;

    localparam int FLG_Z = 3;
    localparam int FLG_C = 2;
    localparam int FLG_N = 1;
    localparam int FLG_O = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_STEP1 = 2'b01,
        ST_STEP2 = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef struct packed {
        logic       hi;
        logic [4:0] funsel;
    } step_t;

    // Which half each pass works on and with which ALU function.
    // Left shifts go low->high, right shifts high->low, so the ALU
    // carry links the two passes in the direction bits move.
    function automatic step_t step_map(op_t op, logic second);
        step_t s;
        s = '{hi: 1'b0, funsel: FS_PASSA16};
        unique case (op)
            OP_ADD32: s = second ? '{1'b1, FS_ADC16} : '{1'b0, FS_ADD16};
            OP_ADC32: s = second ? '{1'b1, FS_ADC16} : '{1'b0, FS_ADC16};
            OP_LSL32: s = second ? '{1'b1, FS_CSL16} : '{1'b0, FS_LSL16};
            OP_LSR32: s = second ? '{1'b0, FS_CSR16} : '{1'b1, FS_LSR16};
            default:  s = '{hi: 1'b0, funsel: FS_PASSA16};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ArithmeticLogicUnit.sv
// 16-bit ALU: combinational ALUOut, flags {Z,C,N,O} registered when WF=1.
// Ports: A, B, FunSel (bit4=1 16-bit mode), WF, Clock -> ALUOut, FlagsOut.
module ArithmeticLogicUnit (
    input  logic        Clock,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [4:0]  FunSel,
    input  logic        WF,
    output logic [15:0] ALUOut,
    output logic [3:0]  FlagsOut
);

    logic [16:0] sum;
    logic        c_nxt;
    logic        o_nxt;

    always_comb begin
        sum    = 17'd0;
        ALUOut = 16'd0;
        c_nxt  = FlagsOut[2];
        o_nxt  = FlagsOut[0];
        unique case (FunSel[3:0])
            4'b0000: ALUOut = A;
            4'b0001: ALUOut = B;
            4'b0010: ALUOut = ~A;
            4'b0011: ALUOut = ~B;
            4'b0100, 4'b0101, 4'b0110: begin
                if (FunSel[3:0] == 4'b0100)
                    sum = {1'b0, A} + {1'b0, B};
                else if (FunSel[3:0] == 4'b0101)
                    sum = {1'b0, A} + {1'b0, B} + {16'd0, FlagsOut[2]};
                else
                    sum = {1'b0, A} + {1'b0, ~B} + 17'd1;
                ALUOut = sum[15:0];
                c_nxt  = sum[16];
                if (FunSel[3:0] == 4'b0110)
                    o_nxt = (A[15] != B[15]) && (sum[15] != A[15]);
                else
                    o_nxt = (A[15] == B[15]) && (sum[15] != A[15]);
            end
            4'b0111: ALUOut = A & B;
            4'b1000: ALUOut = A | B;
            4'b1001: ALUOut = A ^ B;
            4'b1010: ALUOut = ~(A & B);
            4'b1011: begin ALUOut = {A[14:0], 1'b0};        c_nxt = A[15]; end
            4'b1100: begin ALUOut = {1'b0, A[15:1]};        c_nxt = A[0];  end
            4'b1101: begin ALUOut = {A[15], A[15:1]};       c_nxt = A[0];  end
            4'b1110: begin ALUOut = {A[14:0], FlagsOut[2]}; c_nxt = A[15]; end
            4'b1111: begin ALUOut = {FlagsOut[2], A[15:1]}; c_nxt = A[0];  end
            default: ALUOut = 16'd0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (WF)
            FlagsOut <= {ALUOut == 16'd0, c_nxt, ALUOut[15], o_nxt};
    end

endmodule

// File: rtl/alu_wide_sequencer.sv
// Runs 32-bit ADD/ADC/LSL/LSR as two chained passes through a 16-bit ALU.
// Ports: Clock, Reset (sync, low); Req*/Rsp* handshakes; Alu* to/from the ALU.
module alu_wide_sequencer
    import alu_seq_pkg::*;
#(
    parameter int ALU_W = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [1:0]         ReqOp,
    input  logic [2*ALU_W-1:0] ReqA,
    input  logic [2*ALU_W-1:0] ReqB,
    output logic               RspValid,
    input  logic               RspReady,
    output logic [2*ALU_W-1:0] RspResult,
    output logic [3:0]         RspFlags,
    output logic [ALU_W-1:0]   AluA,
    output logic [ALU_W-1:0]   AluB,
    output logic [4:0]         AluFunSel,
    output logic               AluWF,
    input  logic [ALU_W-1:0]   AluOut,
    input  logic [3:0]         AluFlags
);

    state_t             state;
    state_t             state_nxt;
    op_t                op_q;
    logic [2*ALU_W-1:0] a_q;
    logic [2*ALU_W-1:0] b_q;
    logic [2*ALU_W-1:0] res_q;
    step_t              step;
    logic               is_shift;

    always_ff @(posedge Clock) begin
        if (!Reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (ReqValid) state_nxt = ST_STEP1;
            ST_STEP1: state_nxt = ST_STEP2;
            ST_STEP2: state_nxt = ST_DONE;
            ST_DONE:  if (RspReady) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            op_q  <= OP_ADD32;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (state == ST_IDLE && ReqValid) begin
                op_q <= op_t'(ReqOp);
                a_q  <= ReqA;
                b_q  <= ReqB;
            end
            // ALU latches its carry on this same edge
            if (AluWF) begin
                if (step.hi)
                    res_q[2*ALU_W-1:ALU_W] <= AluOut;
                else
                    res_q[ALU_W-1:0] <= AluOut;
            end
        end
    end

    assign is_shift = (op_q == OP_LSL32) || (op_q == OP_LSR32);

    always_comb begin
        step      = step_map(op_q, state == ST_STEP2);
        AluWF     = 1'b0;
        AluA      = '0;
        AluB      = '0;
        AluFunSel = FS_PASSA16;
        if (state == ST_STEP1 || state == ST_STEP2) begin
            AluWF     = 1'b1;
            AluFunSel = step.funsel;
            AluA      = step.hi ? a_q[2*ALU_W-1:ALU_W] : a_q[ALU_W-1:0];
            if (!is_shift)
                AluB = step.hi ? b_q[2*ALU_W-1:ALU_W] : b_q[ALU_W-1:0];
        end
    end

    assign ReqReady  = (state == ST_IDLE);
    assign RspValid  = (state == ST_DONE);
    assign RspResult = res_q;

    // Z/N come from the full 32-bit result; the ALU only saw one half
    always_comb begin
        RspFlags        = 4'b0000;
        RspFlags[FLG_Z] = (res_q == '0);
        RspFlags[FLG_C] = AluFlags[FLG_C];
        RspFlags[FLG_N] = res_q[2*ALU_W-1];
        RspFlags[FLG_O] = is_shift ? 1'b0 : AluFlags[FLG_O];
    end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Directed bench for alu_wide_sequencer driving a real 16-bit ALU.
// Expected values are hand-computed from the two-pass algorithm.
module tb_alu_wide_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspResult;
    logic [3:0]  RspFlags;
    logic [15:0] AluA;
    logic [15:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [15:0] AluOut;
    logic [3:0]  AluFlags;

    int total = 0;
    int bad   = 0;

    always #5 Clock = ~Clock;

    alu_wide_sequencer #(.ALU_W(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
        .ReqA(ReqA), .ReqB(ReqB),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspResult(RspResult), .RspFlags(RspFlags),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags)
    );

    ArithmeticLogicUnit alu (
        .Clock(Clock), .A(AluA), .B(AluB), .FunSel(AluFunSel),
        .WF(AluWF), .ALUOut(AluOut), .FlagsOut(AluFlags)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check latency, result and flags; optionally release.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_f,
                          input bit release_rsp);
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b;
        chk({tag, "_reqready"}, 32'(ReqReady), 32'd1);
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        chk({tag, "_lat1"}, 32'(RspValid), 32'd0);
        @(posedge Clock); #1;
        chk({tag, "_lat2"}, 32'(RspValid), 32'd0);
        @(posedge Clock); #1;
        chk({tag, "_valid"}, 32'(RspValid), 32'd1);
        chk({tag, "_result"}, RspResult, exp_r);
        chk({tag, "_flags"}, 32'(RspFlags), 32'(exp_f));
        chk({tag, "_wf"}, 32'(AluWF), 32'd0);
        if (release_rsp) begin
            @(negedge Clock); RspReady = 1'b1;
            @(posedge Clock); #1;
            RspReady = 1'b0;
            chk({tag, "_idle"}, 32'(ReqReady), 32'd1);
        end
    endtask

    initial begin
        Reset = 1'b0; ReqValid = 1'b0; ReqOp = 2'b00;
        ReqA = '0; ReqB = '0; RspReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_valid", 32'(RspValid), 32'd0);
        chk("rst_result", RspResult, 32'd0);
        chk("rst_wf", 32'(AluWF), 32'd0);
        chk("rst_funsel", 32'(AluFunSel), 32'h10);
        @(negedge Clock); Reset = 1'b1;

        // low FFFF+1 carries into high 0+0+C
        run_op("add_c", 2'b00, 32'h0000FFFF, 32'h1, 32'h00010000, 4'b0000, 1);
        run_op("add_ov", 2'b00, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0011, 1);
        run_op("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b1100, 1);
        // ADC picks up C=1 left by the previous op
        run_op("adc", 2'b01, 32'h0, 32'h0, 32'h00000001, 4'b0000, 1);
        run_op("lsl", 2'b10, 32'h80008000, 32'hFFFF, 32'h00010000, 4'b0100, 1);
        run_op("lsr", 2'b11, 32'h00010001, 32'hFFFF, 32'h00008000, 4'b0100, 1);

        // backpressure: hold in DONE, new requests must be ignored
        run_op("bp", 2'b00, 32'h12345678, 32'h11111111, 32'h23456789, 4'b0000, 0);
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = 2'b11; ReqA = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1;
            chk("bp_valid", 32'(RspValid), 32'd1);
            chk("bp_result", RspResult, 32'h23456789);
            chk("bp_flags", 32'(RspFlags), 32'd0);
            chk("bp_ready", 32'(ReqReady), 32'd0);
            chk("bp_wf", 32'(AluWF), 32'd0);
        end
        ReqValid = 1'b0;
        @(negedge Clock); RspReady = 1'b1;
        @(posedge Clock); #1;
        RspReady = 1'b0;
        chk("bp_release", 32'(ReqReady), 32'd1);

        // reset during STEP2
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = 2'b00; ReqA = 32'h5; ReqB = 32'h6;
        @(posedge Clock); #1;
        ReqValid = 1'b0;
        @(posedge Clock); #1;
        chk("mid_step2_wf", 32'(AluWF), 32'd1);
        @(negedge Clock); Reset = 1'b0;
        @(posedge Clock); #1;
        chk("mid_rst_ready", 32'(ReqReady), 32'd1);
        chk("mid_rst_valid", 32'(RspValid), 32'd0);
        chk("mid_rst_result", RspResult, 32'd0);
        chk("mid_rst_wf", 32'(AluWF), 32'd0);
        @(negedge Clock); Reset = 1'b1;
        run_op("post_rst", 2'b00, 32'h1, 32'h2, 32'h00000003, 4'b0000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
